// File: rtl/instruction_fetch_pkg.sv
// instruction_fetch_pkg: shared widths, memory-size default and fetch state encoding.
package instruction_fetch_pkg;
  localparam int IMEM_BYTES_DEF = 128;
  localparam int INST_W = 32;
  localparam int ADDR_W = 32;
  typedef enum logic [1:0] {RUN, DRAIN, HALT} fetch_state_t;
endpackage

// File: rtl/instruction_fetch_fifo.sv
// fetch_fifo: 2-entry synchronous FIFO with flush; caller guarantees no overflow/underflow.
module fetch_fifo #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic         i_flush,
  input  logic [W-1:0] i_data,
  output logic [1:0]   o_count,
  output logic [W-1:0] o_head
);
  logic [W-1:0] r_mem [2];
  logic         r_wr, r_rd;
  logic [1:0]   r_count;
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wr    <= 1'b0;
      r_rd    <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (i_push) begin
        r_mem[r_wr] <= i_data;
        r_wr        <= ~r_wr;
      end
      if (i_pop) r_rd <= ~r_rd;
      r_count <= r_count + {1'b0, i_push} - {1'b0, i_pop};
    end
  end
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd];
endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC sequencing into a 2-entry buffer, with redirect, drain and halt at end of memory.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC   = 32'h0000_0000,
  parameter int                IMEM_BYTES = IMEM_BYTES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [INST_W-1:0] imem_inst,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  input  logic              id_ready,
  output logic              if_valid,
  output logic [INST_W-1:0] if_inst,
  output logic [ADDR_W-1:0] if_pc,
  output logic              halted
);
  fetch_state_t                r_state, w_state_nxt;
  logic [ADDR_W-1:0]           r_pc, w_pc_nxt;
  logic [1:0]                  w_count;
  logic [ADDR_W+INST_W-1:0]    w_head;
  logic                        w_in_range, w_pop, w_push, w_empty_nxt;
  assign w_in_range  = r_pc < ADDR_W'(IMEM_BYTES);
  assign w_pop       = if_valid && id_ready && !redirect_valid;
  assign w_push      = r_state == RUN && w_in_range && !redirect_valid && (w_count < 2'd2 || w_pop);
  assign w_empty_nxt = w_count == 2'd0 || (w_count == 2'd1 && w_pop && !w_push);
  always_comb begin
    w_state_nxt = redirect_valid ? RUN
                : (r_state == RUN && !w_in_range) ? DRAIN
                : (r_state == DRAIN && w_empty_nxt) ? HALT
                : r_state;
    w_pc_nxt    = redirect_valid ? (redirect_target & 32'hFFFF_FFFC)
                : w_push ? r_pc + 32'd4
                : r_pc;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RUN;
      r_pc    <= RESET_PC;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
    end
  end
  fetch_fifo #(.W(ADDR_W + INST_W)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (redirect_valid),
    .i_data  ({r_pc, imem_inst}),
    .o_count (w_count),
    .o_head  (w_head)
  );
  assign imem_addr       = r_pc;
  assign if_valid        = w_count != 2'd0;
  assign {if_pc, if_inst} = w_head;
  assign halted          = r_state == HALT;
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed checks of sequencing, backpressure, redirect, end-of-program and reset.
module tb_instruction_fetch;
  logic        clk = 1'b0, rst = 1'b1, redirect_valid = 1'b0, id_ready = 1'b0;
  logic [31:0] redirect_target = 32'h0, imem_addr, imem_inst, if_inst, if_pc;
  logic        if_valid, halted;
  int          n_chk = 0, n_err = 0;
  logic [31:0] exp_pc;
  always #5 clk = ~clk;
  assign imem_inst = imem_addr ^ 32'hDEAD_0000;
  instruction_fetch dut (
    .clk             (clk),
    .rst             (rst),
    .imem_addr       (imem_addr),
    .imem_inst       (imem_inst),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .id_ready        (id_ready),
    .if_valid        (if_valid),
    .if_inst         (if_inst),
    .if_pc           (if_pc),
    .halted          (halted)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    step();
    step();
    chk("rst_valid", {31'b0, if_valid}, 32'd0);
    chk("rst_halted", {31'b0, halted}, 32'd0);
    chk("rst_addr", imem_addr, 32'd0);
    id_ready = 1'b1;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("seq_valid", {31'b0, if_valid}, 32'd1);
      chk("seq_pc", if_pc, 32'(4 * i));
      chk("seq_inst", if_inst, 32'(4 * i) ^ 32'hDEAD_0000);
    end
    rst = 1'b1;
    id_ready = 1'b0;
    step();
    rst = 1'b0;
    chk("bp_rst_valid", {31'b0, if_valid}, 32'd0);
    for (int i = 0; i < 5; i++) step();
    chk("bp_valid", {31'b0, if_valid}, 32'd1);
    chk("bp_pc_hold", if_pc, 32'd0);
    chk("bp_addr_hold", imem_addr, 32'd8);
    id_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("bp_resume_valid", {31'b0, if_valid}, 32'd1);
      chk("bp_resume_pc", if_pc, 32'(4 * i));
      step();
    end
    rst = 1'b1;
    id_ready = 1'b0;
    step();
    rst = 1'b0;
    step();
    step();
    chk("rd_full_pc", if_pc, 32'd0);
    redirect_valid = 1'b1;
    redirect_target = 32'h41;
    id_ready = 1'b1;
    step();
    redirect_valid = 1'b0;
    chk("rd_flush_valid", {31'b0, if_valid}, 32'd0);
    chk("rd_addr", imem_addr, 32'h40);
    step();
    chk("rd_first_valid", {31'b0, if_valid}, 32'd1);
    chk("rd_first_pc", if_pc, 32'h40);
    step();
    chk("rd_second_pc", if_pc, 32'h44);
    exp_pc = 32'h44;
    for (int i = 0; i < 100 && !halted; i++) begin
      if (if_valid) begin
        chk("end_seq_pc", if_pc, exp_pc);
        exp_pc += 32'd4;
      end
      step();
    end
    chk("end_halted", {31'b0, halted}, 32'd1);
    chk("end_last_pc", exp_pc, 32'd128);
    chk("end_valid", {31'b0, if_valid}, 32'd0);
    chk("end_addr", imem_addr, 32'd128);
    step();
    step();
    chk("end_halted_hold", {31'b0, halted}, 32'd1);
    chk("end_addr_hold", imem_addr, 32'd128);
    redirect_valid = 1'b1;
    redirect_target = 32'h0;
    step();
    redirect_valid = 1'b0;
    chk("restart_halted", {31'b0, halted}, 32'd0);
    chk("restart_valid", {31'b0, if_valid}, 32'd0);
    step();
    chk("restart_valid2", {31'b0, if_valid}, 32'd1);
    chk("restart_pc", if_pc, 32'd0);
    id_ready = 1'b0;
    step();
    chk("mr_full_pc", if_pc, 32'd0);
    chk("mr_full_addr", imem_addr, 32'd8);
    rst = 1'b1;
    step();
    rst = 1'b0;
    id_ready = 1'b1;
    chk("mr_valid", {31'b0, if_valid}, 32'd0);
    chk("mr_halted", {31'b0, halted}, 32'd0);
    chk("mr_addr", imem_addr, 32'd0);
    step();
    chk("mr_first_valid", {31'b0, if_valid}, 32'd1);
    chk("mr_first_pc", if_pc, 32'd0);
    step();
    chk("mr_second_pc", if_pc, 32'd4);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
